tt_um_example: RTL and testbench
================================

TT_UM_EXAMPLE -- requirements
Module: tt_um_example

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a new button level.
REQ-002 Parameter WDG_TIMEOUT_CYCLES, default 25_000_000: kick-free cycles before watchdog expiry (500 ms at 50 MHz).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ena  input  1  power-good indication; ignored.
REQ-006 ui_in  input  8:
  - [0] estop_a_n, E-STOP A, active-low.
  - [1] estop_b_n, E-STOP B, active-low.
  - [2] ack_n, acknowledge button, active-low.
  - [3] wdg_kick, watchdog kick, active-high pulse.
  - [7:4] unused.
REQ-007 uo_out  output  8:
  - [0] shutdown, 1 = outputs de-energized.
  - [1] led_status, equal to shutdown.
  - [2] wdg_ok.
  - [3] armed, 1 in state ARMED.
  - [7:4] 0.
REQ-008 uio_in  input  8  unused.
REQ-009 uio_out  output  8  constant 0.
REQ-010 uio_oe  output  8  constant 0.

Function
REQ-011 ui_in[3:0] SHALL each pass through a 2-FF synchronizer.
REQ-012 The debounced level of estop_a_n, estop_b_n and ack_n SHALL update only after DEBOUNCE_CYCLES consecutive identical synchronized samples; a 10-cycle ack_n low pulse SHALL be accepted.
REQ-013 estop_active SHALL be 1 when either debounced E-STOP level is 0.
REQ-014 ack_press SHALL be a one-cycle pulse on the 1->0 transition of debounced ack_n.
REQ-015 kick SHALL be a one-cycle pulse on the 0->1 transition of synchronized wdg_kick; no debounce.
REQ-016 Watchdog on kick: counter SHALL clear to 0 and wdg_ok SHALL set to 1.
REQ-017 Watchdog otherwise, while wdg_ok=1: counter SHALL increment; at count WDG_TIMEOUT_CYCLES-1, wdg_ok SHALL clear to 0 and the counter SHALL hold.
REQ-018 If kick and expiry occur in the same cycle, the kick SHALL win.
REQ-019 The FSM SHALL have states SHUTDOWN, ARMED and RUN.
REQ-020 SHUTDOWN -> ARMED on ack_press with estop_active=0; ack_press with estop_active=1 SHALL be ignored and not remembered.
REQ-021 ARMED -> SHUTDOWN on estop_active; otherwise ARMED -> RUN when wdg_ok=1; ARMED SHALL otherwise hold indefinitely.
REQ-022 RUN -> SHUTDOWN on estop_active or wdg_ok=0; RUN SHALL never be left by E-STOP release alone, and re-entry SHALL always require a new ack_press.
REQ-023 Priority SHALL be estop_active > watchdog expiry > ack_press.
REQ-024 shutdown SHALL be a registered output equal to (state != RUN).
REQ-025 Latency from E-STOP input low to shutdown=1 SHALL be at most DEBOUNCE_CYCLES+4 cycles.
REQ-026 Latency from kick input rise (while ARMED) to shutdown=0 SHALL be at most 5 cycles.

Reset
REQ-027 On rst=1 at a clock edge: state SHALL go to SHUTDOWN, wdg_ok to 0 and counter to 0.
REQ-028 On reset, synchronizer and debounced values SHALL go to released levels (active-low inputs 1, wdg_kick 0), so no edge is generated on reset exit.
REQ-029 During and after reset, uo_out SHALL be 8'b0000_0011.
REQ-030 Reset mid-operation SHALL force SHUTDOWN regardless of state.

Structure
REQ-031 State encoding and default parameter constants SHALL reside in a shared package.
REQ-032 One sub-module, esd_debounce (synchronizer plus stability filter, parameterized by DEBOUNCE_CYCLES), SHALL be instantiated three times; watchdog and FSM SHALL live in the top module.

Verification (bench overrides WDG_TIMEOUT_CYCLES=2000, kicks every 800 cycles)
REQ-033 Reset, E-STOPs released, no kicks, 10-cycle ACK -> uo_out[1:0]=11, armed=1; start kicks -> uo_out[1:0]=00 within 5 cycles of first kick.
REQ-034 In RUN, estop_a_n low -> shutdown=1 within 8 cycles; release alone -> stays 1; ACK -> 00.
REQ-035 Both E-STOPs low; release A; ACK -> stays 11, armed=0; release B; ACK -> 00.
REQ-036 In RUN, stop kicks -> shutdown=1 exactly 2000 cycles after last kick pulse (plus sync latency); ACK, resume kicks -> 00.
REQ-037 In RUN: E-STOP A pulse, then E-STOP B pulse, each 1000 cycles -> shutdown stays 1 until ACK, then 00.
REQ-038 Glitch on estop_a_n of 3 cycles low -> no shutdown; assert rst in RUN -> uo_out=8'h03 on the next cycle.

Source files
------------

// File: rtl/tt_um_example_pkg.sv
// tt_um_example_pkg: shared FSM state encoding and default timing constants for the E-STOP controller
package tt_um_example_pkg;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned WDG_TIMEOUT_CYCLES_DEF = 25_000_000;
  typedef enum logic [1:0] {
    ST_SHUTDOWN = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUN      = 2'd2
  } state_e;
endpackage

// File: rtl/tt_um_example_esd_debounce.sv
// esd_debounce: 2-FF synchronizer plus stability filter for one button line
// clk/rst: clock and sync active-high reset; in_i: raw async input; level_o: debounced level (RST_VAL after reset)
module esd_debounce
  import tt_um_example_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic        RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, lvl_q;
  logic [CW-1:0] cnt_q;
  // cnt_q counts consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      lvl_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      if (s2_q == lvl_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign level_o = lvl_q;
endmodule

// File: rtl/tt_um_example.sv
// tt_um_example: dual E-STOP safety controller with acknowledge, watchdog and SHUTDOWN/ARMED/RUN FSM
// ui_in[0] estop_a_n, [1] estop_b_n, [2] ack_n, [3] wdg_kick; uo_out[0] shutdown, [1] led_status, [2] wdg_ok, [3] armed
// ena, uio_in and ui_in[7:4] are unused; uio_out and uio_oe are tied low
module tt_um_example
  import tt_um_example_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WDG_TIMEOUT_CYCLES = WDG_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int unsigned WC = $clog2(WDG_TIMEOUT_CYCLES + 1);
  logic est_a_lvl, est_b_lvl, ack_lvl, ack_prev_q;
  logic kick_s1_q, kick_s2_q, kick_prev_q;
  logic estop_active, ack_press, kick, wdg_ok_q, shutdown_q;
  logic [WC-1:0] wdg_cnt_q;
  state_e state_q, state_d;
  logic unused;
  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_estop_a (
    .clk(clk), .rst(rst), .in_i(ui_in[0]), .level_o(est_a_lvl)
  );
  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_estop_b (
    .clk(clk), .rst(rst), .in_i(ui_in[1]), .level_o(est_b_lvl)
  );
  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_ack (
    .clk(clk), .rst(rst), .in_i(ui_in[2]), .level_o(ack_lvl)
  );
  assign estop_active = !est_a_lvl || !est_b_lvl;
  assign ack_press = ack_prev_q && !ack_lvl;
  assign kick = kick_s2_q && !kick_prev_q;
  // estop dominates everywhere; an ack seen during estop is dropped, not latched
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SHUTDOWN: state_d = (ack_press && !estop_active) ? ST_ARMED : ST_SHUTDOWN;
      ST_ARMED:    state_d = estop_active ? ST_SHUTDOWN : wdg_ok_q ? ST_RUN : ST_ARMED;
      ST_RUN:      state_d = (estop_active || !wdg_ok_q) ? ST_SHUTDOWN : ST_RUN;
      default:     state_d = ST_SHUTDOWN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      kick_s1_q <= 1'b0;
      kick_s2_q <= 1'b0;
      kick_prev_q <= 1'b0;
      ack_prev_q <= 1'b1;
      wdg_cnt_q <= '0;
      wdg_ok_q <= 1'b0;
      state_q <= ST_SHUTDOWN;
      shutdown_q <= 1'b1;
    end else begin
      kick_s1_q <= ui_in[3];
      kick_s2_q <= kick_s1_q;
      kick_prev_q <= kick_s2_q;
      ack_prev_q <= ack_lvl;
      state_q <= state_d;
      shutdown_q <= state_d != ST_RUN;
      // a kick overrides a simultaneous expiry; after expiry the count freezes
      if (kick) begin
        wdg_cnt_q <= '0;
        wdg_ok_q <= 1'b1;
      end else if (wdg_ok_q) begin
        if (wdg_cnt_q == WC'(WDG_TIMEOUT_CYCLES - 1)) wdg_ok_q <= 1'b0;
        else wdg_cnt_q <= wdg_cnt_q + WC'(1);
      end
    end
  end
  assign uo_out = {4'b0000, state_q == ST_ARMED, wdg_ok_q, shutdown_q, shutdown_q};
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:4]};
endmodule

// File: tb/tb_tt_um_example.sv
// tb_tt_um_example: directed and randomized checks of tt_um_example against a window/elapsed-time reference model
module tb_tt_um_example;
  localparam int DB = 4;
  localparam int T = 2000;
  localparam int KP = 800;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic a_n = 1'b1, b_n = 1'b1, ack_n = 1'b1, kick_en = 1'b0;
  int kph = 0, kw = 1, vec = 0, miss = 0;
  logic [3:0] hq [0:DB];
  logic [2:0] m_lvl;
  logic m_akp, m_ok, m_have;
  int m_st, m_last = 0, cyc = 0;
  logic [7:0] exp_uo;

  tt_um_example #(.DEBOUNCE_CYCLES(DB), .WDG_TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: inputs become visible two edges late; a level is accepted once the last DB
  // visible samples all agree; wdg_ok holds for T edges after the edge that saw a kick.
  task automatic model_edge();
    logic est, ackp, kick, same;
    if (rst) begin
      for (int i = 0; i <= DB; i++) hq[i] = 4'b0111;
      m_lvl = 3'b111;
      m_akp = 1'b1;
      m_ok = 1'b0;
      m_have = 1'b0;
      m_st = 0;
    end else begin
      est = !m_lvl[0] || !m_lvl[1];
      ackp = m_akp && !m_lvl[2];
      kick = hq[1][3] && !hq[2][3];
      if (m_st == 0) m_st = (ackp && !est) ? 1 : 0;
      else if (m_st == 1) m_st = est ? 0 : (m_ok ? 2 : 1);
      else m_st = (est || !m_ok) ? 0 : 2;
      if (kick) begin
        m_have = 1'b1;
        m_last = cyc;
      end
      m_ok = m_have && (cyc - m_last < T);
      m_akp = m_lvl[2];
      for (int b = 0; b < 3; b++) begin
        same = 1'b1;
        for (int k = 2; k <= DB; k++) if (hq[k][b] != hq[1][b]) same = 1'b0;
        if (same) m_lvl[b] = hq[1][b];
      end
      for (int i = DB; i > 0; i--) hq[i] = hq[i-1];
      hq[0] = ui_in[3:0];
    end
    cyc++;
    exp_uo = {4'b0000, m_st == 1, m_ok, m_st != 2, m_st != 2};
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      vec++;
      assert (uo_out === exp_uo && uio_out === 8'h00 && uio_oe === 8'h00)
        else begin
          miss++;
          $error("FAIL cycle %0d: uo_out=%h uio_out=%h uio_oe=%h expected %h/00/00", cyc, uo_out, uio_out, uio_oe, exp_uo);
        end
      if (kick_en) kph = (kph + 1) % KP;
      ui_in = {4'($urandom), kick_en && (kph < kw), ack_n, b_n, a_n};
      uio_in = 8'($urandom);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vec++;
    assert (obs === want)
      else begin
        miss++;
        $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
  endtask

  task automatic chk_rng(input string tag, input int n, input int lo, input int hi);
    vec++;
    assert (n >= lo && n <= hi)
      else begin
        miss++;
        $error("FAIL %s: observed %0d cycles expected %0d..%0d", tag, n, lo, hi);
      end
  endtask

  task automatic wait_sd(input logic v, input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (uo_out[0] !== v && n < budget);
  endtask

  task automatic press();
    ack_n = 1'b0;
    step(10 + int'($urandom_range(0, 5)));
    ack_n = 1'b1;
    step(12);
  endtask

  initial begin
    int n;
    ui_in = 8'h07;
    uio_in = 8'h00;
    step(3);
    chk("reset", uo_out, 8'h03);
    rst = 1'b0;
    step(10);
    chk("idle", uo_out, 8'h03);
    press();
    chk("armed_no_kick", uo_out, 8'h0B);
    step(100 + int'($urandom_range(0, 200)));
    chk("armed_hold", uo_out, 8'h0B);
    kw = int'($urandom_range(1, 3));
    kph = KP - 1;
    kick_en = 1'b1;
    wait_sd(1'b0, 20, n);
    chk_rng("kick_to_run", n, 1, 5);
    chk("run", uo_out, 8'h04);
    step(50);
    a_n = 1'b0;
    wait_sd(1'b1, 20, n);
    chk_rng("estop_a_latency", n, 1, 8);
    step(int'($urandom_range(20, 60)));
    a_n = 1'b1;
    step(40 + int'($urandom_range(0, 100)));
    chk("estop_release_stays", uo_out, 8'h07);
    press();
    chk("rearm_a", uo_out, 8'h04);
    a_n = 1'b0;
    b_n = 1'b0;
    step(30);
    a_n = 1'b1;
    step(30);
    press();
    chk("ack_with_b_held", uo_out, 8'h07);
    b_n = 1'b1;
    step(30);
    chk("b_release_no_rearm", uo_out, 8'h07);
    press();
    chk("rearm_b", uo_out, 8'h04);
    while (kph != 5) step(1);
    kick_en = 1'b0;
    wait_sd(1'b1, 2100, n);
    chk_rng("wdg_expiry", n, 1995, 2003);
    step(5);
    chk("expired", uo_out, 8'h03);
    press();
    chk("armed_expired", uo_out, 8'h0B);
    kph = KP - 1;
    kick_en = 1'b1;
    wait_sd(1'b0, 20, n);
    chk_rng("resume_kick", n, 1, 5);
    chk("run_resumed", uo_out, 8'h04);
    step(50);
    a_n = 1'b0;
    step(1000);
    a_n = 1'b1;
    step(50);
    b_n = 1'b0;
    step(1000);
    b_n = 1'b1;
    step(50);
    chk("after_pulses", uo_out, 8'h07);
    press();
    chk("rearm_pulses", uo_out, 8'h04);
    for (int g = 0; g < 4; g++) begin
      a_n = 1'b0;
      step(int'($urandom_range(1, 3)));
      a_n = 1'b1;
      step(10);
      chk("glitch", uo_out, 8'h04);
    end
    kick_en = 1'b0;
    rst = 1'b1;
    step(1);
    chk("reset_in_run", uo_out, 8'h03);
    rst = 1'b0;
    step(20);
    chk("after_reset", uo_out, 8'h03);
    kick_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) a_n = ~a_n;
      if ($urandom_range(0, 59) == 0) b_n = ~b_n;
      if ($urandom_range(0, 29) == 0) ack_n = ~ack_n;
      if ($urandom_range(0, 1499) == 0) kick_en = ~kick_en;
      rst = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst = 1'b0;
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
